// File: rtl/linear_forward.sv
// Fully-connected forward stage z = W*x + b (Q8.8), one column of W per cycle across M MAC lanes.
// Packing: W[j][k] at bits [(j*N+k)*16 +: 16], x[k] at [k*16 +: 16], b[j] and z[j] at [j*16 +: 16].
//
// state | meaning
// IDLE  | waiting for start; snapshots W, x, b when start is accepted
// LOAD  | accumulators preloaded with bias (Q16.16)
// ACC   | one column k of W multiplied by x[k] and accumulated per cycle
// WRITE | floor-shift and saturate accumulators into z; done follows
module linear_forward #(
    parameter int M = 5,
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [M*N*16-1:0] W,
    input  logic [N*16-1:0]   x,
    input  logic [M*16-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [M*16-1:0]   z
);

    localparam int AW = 32 + $clog2(N + 1) + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, WRITE} state_t;

    state_t state, state_nxt;
    logic [KW-1:0] k;

    logic signed [15:0]   w_snap [M][N];
    logic signed [15:0]   x_snap [N];
    logic signed [15:0]   b_snap [M];
    logic signed [AW-1:0] acc    [M];
    logic signed [31:0]   prod   [M];
    logic signed [15:0]   x_col;

    function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> 8;
        if (s > SAT_MAX)
            return 16'h7FFF;
        else if (s < SAT_MIN)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ACC;
            ACC:     if (k == KW'(N - 1)) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_col = x_snap[k];
        for (int j = 0; j < M; j++)
            prod[j] = w_snap[j][k] * x_col;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k    <= '0;
            done <= 1'b0;
            z    <= '0;
            for (int j = 0; j < M; j++) begin
                acc[j]    <= '0;
                b_snap[j] <= '0;
                for (int kk = 0; kk < N; kk++)
                    w_snap[j][kk] <= '0;
            end
            for (int kk = 0; kk < N; kk++)
                x_snap[kk] <= '0;
        end else begin
            done <= (state == WRITE);
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int j = 0; j < M; j++) begin
                            b_snap[j] <= b[j*16 +: 16];
                            for (int kk = 0; kk < N; kk++)
                                w_snap[j][kk] <= W[(j*N+kk)*16 +: 16];
                        end
                        for (int kk = 0; kk < N; kk++)
                            x_snap[kk] <= x[kk*16 +: 16];
                    end
                end
                LOAD: begin
                    k <= '0;
                    for (int j = 0; j < M; j++)
                        acc[j] <= {{(AW-24){b_snap[j][15]}}, b_snap[j], 8'h00};
                end
                ACC: begin
                    k <= k + 1'b1;
                    for (int j = 0; j < M; j++)
                        acc[j] <= acc[j] + AW'(prod[j]);
                end
                WRITE: begin
                    for (int j = 0; j < M; j++)
                        z[j*16 +: 16] <= sat16(acc[j]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_forward.sv
// Directed bench for linear_forward: reset, nominal, saturation, floor, back-to-back handshake, abort.
module tb_linear_forward;
    localparam int M = 5;
    localparam int N = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [M*N*16-1:0] W;
    logic [N*16-1:0]   x;
    logic [M*16-1:0]   b;
    logic              busy;
    logic              done;
    logic [M*16-1:0]   z;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    linear_forward #(.M(M), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .W     (W),
        .x     (x),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_z(input string tag, input logic [15:0] e0, input logic [15:0] erest);
        check($sformatf("%s z0", tag), {16'h0, z[15:0]}, {16'h0, e0});
        for (int j = 1; j < M; j++)
            check($sformatf("%s z%0d", tag, j), {16'h0, z[j*16 +: 16]}, {16'h0, erest});
    endtask

    task automatic set_nominal;
        W = {(M*N){16'h0100}};
        x = {16'h0300, 16'h0200, 16'h0100};
        b = {M{16'h0080}};
    endtask

    task automatic set_floor;
        W = '0;
        W[15:0] = 16'hFFFF;
        x = '0;
        x[15:0] = 16'h0080;
        b = '0;
    endtask

    // Pulses start, then waits (bounded) for done; returns latency and busy-cycle count.
    task automatic run_op(output int lat, output int busy_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bn, npulse, ndone;
        int pulse_at [3];
        logic [15:0] z0_at [3];
        logic [15:0] z1_at [3];

        reset = 1'b1;
        start = 1'b0;
        W = '0;
        x = '0;
        b = '0;
        tick();
        tick();
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check_z("rst", 16'h0000, 16'h0000);
        reset = 1'b0;
        tick();

        // nominal: 1*1 + 1*2 + 1*3 + 0.5 = 6.5
        set_nominal();
        run_op(lat, bn);
        check("nom latency", lat, 5);
        check("nom busy cycles", bn, 5);
        check("nom done", {31'h0, done}, 32'h1);
        check("nom busy at done", {31'h0, busy}, 32'h0);
        check_z("nom", 16'h0680, 16'h0680);
        tick();
        check("nom done single", {31'h0, done}, 32'h0);
        check_z("nom hold", 16'h0680, 16'h0680);

        // async reset mid-cycle, no clock edge in between
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_z("async rst", 16'h0000, 16'h0000);
        check("async rst busy", {31'h0, busy}, 32'h0);
        check("async rst done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        tick();

        // 3 * 127*127 overflows Q8.8 in both directions
        W = {(M*N){16'h7F00}};
        x = {N{16'h7F00}};
        b = '0;
        run_op(lat, bn);
        check("satp latency", lat, 5);
        check_z("satp", 16'h7FFF, 16'h7FFF);
        tick();
        W = {(M*N){16'h8100}};
        run_op(lat, bn);
        check("satn latency", lat, 5);
        check_z("satn", 16'h8000, 16'h8000);
        tick();

        // -1/256 * 0.5 = -1/512 floors to -1 LSB
        set_floor();
        run_op(lat, bn);
        check("floor latency", lat, 5);
        check_z("floor", 16'hFFFF, 16'h0000);
        tick();

        // start held high; inputs change one cycle after first acceptance
        set_nominal();
        start = 1'b1;
        tick();
        npulse = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1) set_floor();
            if (done) begin
                if (npulse < 3) begin
                    pulse_at[npulse] = c;
                    z0_at[npulse] = z[15:0];
                    z1_at[npulse] = z[31:16];
                end
                npulse++;
            end
        end
        start = 1'b0;
        check("hs pulses", npulse, 3);
        if (npulse >= 3) begin
            check("hs done1 cycle", pulse_at[0], 5);
            check("hs done2 cycle", pulse_at[1], 11);
            check("hs done3 cycle", pulse_at[2], 17);
            check("hs snap z0", {16'h0, z0_at[0]}, 32'h0680);
            check("hs snap z1", {16'h0, z1_at[0]}, 32'h0680);
            check("hs second z0", {16'h0, z0_at[1]}, 32'hFFFF);
            check("hs second z1", {16'h0, z1_at[1]}, 32'h0000);
        end
        for (int c = 0; c < 8; c++) tick();
        check("hs idle", {31'h0, busy}, 32'h0);

        // abort in ACC, then a clean nominal run
        set_nominal();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort in acc busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check_z("abort", 16'h0000, 16'h0000);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        check_z("abort hold", 16'h0000, 16'h0000);
        run_op(lat, bn);
        check("post abort latency", lat, 5);
        check_z("post abort", 16'h0680, 16'h0680);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
